// File: rtl/button_conditioner_pkg.sv
// Shared types and timing constants for the push-button front end.
// Also the source of ms-scale tick counts for other blocks.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    REPEAT,
    RPT_WAIT,
    WAIT
  } btn_state_t;

  localparam int CLK_HZ       = 100_000_000;
  localparam int TICKS_PER_MS = CLK_HZ / 1000;

  localparam int DEF_DB_CYCLES     = 10 * TICKS_PER_MS;
  localparam int DEF_HOLD_CYCLES   = 500 * TICKS_PER_MS;
  localparam int DEF_REPEAT_CYCLES = 200 * TICKS_PER_MS;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce counter and pulse FSM.
// The pulse is registered and lines up with FSM entry to PRESS/REPEAT.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int DBW = cnt_width(DB_CYCLES);
  localparam int TMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = cnt_width(TMAX);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  RPT_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0]  TIM_MAX   = TW'(TMAX);

  logic           meta;
  logic           sync;
  logic [DBW-1:0] db_cnt;
  logic [DBW-1:0] db_cnt_next;
  logic           level_next;
  btn_state_t     state;
  btn_state_t     state_next;
  logic [TW-1:0]  tmr;
  logic [TW-1:0]  tmr_next;
  logic           pulse;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  // Count consecutive samples that disagree with level; any agreeing
  // sample restarts the window, DB_CYCLES of them flip level.
  always_comb begin
    level_next  = level;
    db_cnt_next = '0;
    if (sync != level) begin
      if (db_cnt >= DB_LAST) begin
        level_next = ~level;
      end else begin
        db_cnt_next = db_cnt + DBW'(1);
      end
    end
  end

  // Debounce state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      db_cnt <= db_cnt_next;
      level  <= level_next;
    end
  end

  // Pulse FSM: the FSM looks at the upcoming level so that the edge
  // on which level falls already cancels any pending pulse.
  always_comb begin
    state_next = state;
    tmr_next   = '0;
    pulse      = 1'b0;
    unique case (state)
      IDLE: begin
        if (level) begin
          state_next = PRESS;
        end
      end
      PRESS: begin
        state_next = REPEAT_EN ? HOLD : WAIT;
      end
      HOLD: begin
        if (tmr >= HOLD_LAST) begin
          state_next = REPEAT;
        end
      end
      REPEAT: begin
        state_next = RPT_WAIT;
      end
      RPT_WAIT: begin
        if (tmr >= RPT_LAST) begin
          state_next = REPEAT;
        end
      end
      WAIT: begin
        state_next = WAIT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!level_next) begin
      state_next = IDLE;
    end
    if (state_next == HOLD || state_next == RPT_WAIT) begin
      tmr_next = (tmr == TIM_MAX) ? tmr : tmr + TW'(1);
    end
    pulse = (state_next == PRESS) || (state_next == REPEAT);
  end

  // FSM, shared hold/repeat timer and registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tmr   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_next;
      tmr   <= tmr_next;
      press <= pulse;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Board push-button conditioner: NB independent channels, each
// giving a debounced level and one-cycle press/repeat pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NB            = 5,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] btn_in,
  output logic [NB-1:0] level,
  output logic [NB-1:0] press
);

  for (genvar g = 0; g < NB; g++) begin : g_ch
    button_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in[g]),
      .level (level[g]),
      .press (press[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (repeat on/off)
// checked every cycle against a window/timestamp model.
module tb_button_conditioner;

  localparam int NB   = 5;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] level_a, press_a;
  logic [NB-1:0] level_b, press_b;

  always #5 clk = ~clk;

  button_conditioner #(
    .NB(NB), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .level(level_a), .press(press_a)
  );

  button_conditioner #(
    .NB(NB), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .level(level_b), .press(press_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: raw samples by edge index since reset release.
  logic [NB-1:0] bs [0:255];
  int            ecount;
  int            tlast [NB];
  int            pedge [NB];
  bit            pval  [NB];
  logic [NB-1:0] mlvl, mp_a, mp_b;

  task automatic model_clear();
    ecount = 0;
    mlvl   = '0;
    mp_a   = '0;
    mp_b   = '0;
    for (int b = 0; b < NB; b++) begin
      tlast[b] = -1;
      pedge[b] = 0;
      pval[b]  = 1'b0;
    end
  endtask

  // Synchronised sample seen at edge k is the pin value two edges earlier.
  function automatic logic samp(input int k, input int b);
    return (k >= 2) ? bs[k-2][b] : 1'b0;
  endfunction

  task automatic model_step(input int e);
    logic prev;
    bit   all;
    int   d;
    bs[e] = btn_in;
    for (int b = 0; b < NB; b++) begin
      prev = mlvl[b];
      if (e - tlast[b] >= DB) begin
        all = 1'b1;
        for (int k = e - DB + 1; k <= e; k++) begin
          if (samp(k, b) == mlvl[b]) all = 1'b0;
        end
        if (all) begin
          mlvl[b]  = ~mlvl[b];
          tlast[b] = e;
        end
      end
      mp_a[b] = 1'b0;
      mp_b[b] = 1'b0;
      if (!prev && mlvl[b]) begin
        pval[b]  = 1'b1;
        pedge[b] = e + 1;
      end
      if (!mlvl[b]) begin
        pval[b] = 1'b0;
      end else if (pval[b] && e >= pedge[b]) begin
        d = e - pedge[b];
        mp_b[b] = (d == 0);
        mp_a[b] = (d == 0) ||
                  (d >= HOLD && ((d - HOLD) % REP) == 0);
      end
    end
  endtask

  // Observations of the DUT, compared to literals per scenario.
  int            pa0 [$];
  int            pa1 [$];
  int            pa2 [$];
  int            pb2 [$];
  int            lv0_rise, lv0_fall, glitch;
  logic          prev0;
  logic [NB-1:0] p6a, p6b;

  task automatic clear_rec();
    pa0.delete();
    pa1.delete();
    pa2.delete();
    pb2.delete();
    lv0_rise = -1;
    lv0_fall = -1;
    glitch   = 0;
    p6a      = '0;
    p6b      = '0;
  endtask

  function automatic int first(input int q [$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Per-cycle compare against the model.
  initial begin
    int e;
    model_clear();
    clear_rec();
    prev0 = 1'b0;
    forever begin
      @(posedge clk);
      e = -1;
      if (!rst) begin
        model_clear();
      end else begin
        e = ecount;
        if (ecount < 256) model_step(e);
        ecount++;
      end
      #1;
      check("level_a", 32'(level_a), 32'(mlvl));
      check("level_b", 32'(level_b), 32'(mlvl));
      check("press_a", 32'(press_a), 32'(mp_a));
      check("press_b", 32'(press_b), 32'(mp_b));
      if (rst) begin
        if (press_a[0]) pa0.push_back(e);
        if (press_a[1]) pa1.push_back(e);
        if (press_a[2]) pa2.push_back(e);
        if (press_b[2]) pb2.push_back(e);
        if (level_a[0] && !prev0) lv0_rise = e;
        if (!level_a[0] && prev0) lv0_fall = e;
        if (e == 6) begin
          p6a = press_a;
          p6b = press_b;
        end
        if (press_a[3:1] != 3'b000 || press_b[3:1] != 3'b000) begin
          glitch++;
        end
      end
      prev0 = rst ? level_a[0] : 1'b0;
    end
  end

  task automatic start();
    @(negedge clk);
    rst    = 1'b0;
    btn_in = '0;
    @(negedge clk);
    @(negedge clk);
    clear_rec();
    rst = 1'b1;
  endtask

  task automatic drive(input logic [NB-1:0] v, input int n);
    repeat (n) begin
      btn_in = v;
      @(negedge clk);
    end
  endtask

  int exp_rep [8] = '{6, 16, 19, 22, 25, 28, 31, 34};

  initial begin
    logic [NB-1:0] v;

    // Clean press on bit 0.
    start();
    drive(5'b00001, 8);
    drive(5'b00000, 14);
    check("clean_rise", 32'(lv0_rise), 32'd5);
    check("clean_npress", 32'(pa0.size()), 32'd1);
    check("clean_press", 32'(first(pa0)), 32'd6);
    check("clean_fall", 32'(lv0_fall), 32'd13);

    // Bounce on bit 1.
    start();
    drive(5'b00010, 2);
    drive(5'b00000, 1);
    drive(5'b00010, 2);
    drive(5'b00000, 1);
    drive(5'b00010, 8);
    drive(5'b00000, 14);
    check("bounce_npress", 32'(pa1.size()), 32'd1);
    check("bounce_press", 32'(first(pa1)), 32'd12);

    // Auto-repeat on bit 2.
    start();
    drive(5'b00100, 30);
    drive(5'b00000, 12);
    check("rpt_n", 32'(pa2.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rpt_edge%0d", i),
            32'((i < pa2.size()) ? pa2[i] : -1),
            32'(exp_rep[i]));
    end
    check("norpt_n", 32'(pb2.size()), 32'd1);
    check("norpt_press", 32'(first(pb2)), 32'd6);

    // Reset mid-repeat with the button still held.
    start();
    drive(5'b00100, 18);
    rst = 1'b0;
    #1;
    check("rst_level_a", 32'(level_a), 32'd0);
    check("rst_press_a", 32'(press_a), 32'd0);
    check("rst_level_b", 32'(level_b), 32'd0);
    check("rst_press_b", 32'(press_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear_rec();
    rst = 1'b1;
    drive(5'b00100, 10);
    drive(5'b00000, 10);
    check("rst_npress", 32'(pa2.size()), 32'd1);
    check("rst_press", 32'(first(pa2)), 32'd6);

    // Two simultaneous presses plus short glitches elsewhere.
    start();
    for (int i = 0; i < 8; i++) begin
      v = 5'b10001;
      if (i >= 1 && i <= 3) v[1] = 1'b1;
      if (i == 2) v[2] = 1'b1;
      if (i >= 4 && i <= 5) v[3] = 1'b1;
      btn_in = v;
      @(negedge clk);
    end
    drive(5'b00000, 14);
    check("multi_a", 32'(p6a), 32'h11);
    check("multi_b", 32'(p6b), 32'h11);
    check("glitch", 32'(glitch), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
